// File: rtl/tc_event_encoder8_if.sv
// tc_event_encoder8_if: event request lines, grant handshake and status flag bundle
// master: drives in0..in7, dis, ready; observes valid, sel0..sel2, lost
// slave : the encoder side, the mirror image of master
interface tc_event_encoder8_if;
  logic in0, in1, in2, in3, in4, in5, in6, in7;
  logic dis, ready;
  logic valid, sel0, sel1, sel2, lost;
  modport master(
    output in0, in1, in2, in3, in4, in5, in6, in7, dis, ready,
    input  valid, sel0, sel1, sel2, lost
  );
  modport slave(
    input  in0, in1, in2, in3, in4, in5, in6, in7, dis, ready,
    output valid, sel0, sel1, sel2, lost
  );
endinterface

// File: rtl/tc_event_encoder8.sv
// tc_event_encoder8: 8-line event encoder with a pending register and a valid/ready grant slot
// clk, rst : clock and synchronous active-high reset
// bus      : slave side of tc_event_encoder8_if (in0..in7, dis, ready in; valid, sel0..sel2, lost out)
// RR_MODE  : 0 = lowest pending index wins, 1 = round-robin starting after the last grant
module tc_event_encoder8 #(
  parameter bit RR_MODE = 1'b0
) (
  input logic clk,
  input logic rst,
  tc_event_encoder8_if.slave bus
);
  logic [7:0] w_in, w_gmask, r_p;
  logic [2:0] w_start, w_g, w_idx, r_sel, r_ptr;
  logic       w_free, w_grant, r_valid, r_lost;
  assign w_in    = {bus.in7, bus.in6, bus.in5, bus.in4, bus.in3, bus.in2, bus.in1, bus.in0};
  assign w_free  = ~r_valid | bus.ready;
  assign w_grant = w_free & ~bus.dis & (|r_p);
  assign w_start = RR_MODE ? r_ptr + 3'd1 : 3'd0;
  // Scan offsets from high to low so the last hit kept is the one closest to w_start.
  always_comb begin
    w_g   = '0;
    w_idx = '0;
    for (int k = 7; k >= 0; k--) begin
      w_idx = w_start + 3'(k);
      w_g   = r_p[w_idx] ? w_idx : w_g;
    end
  end
  assign w_gmask = {7'd0, w_grant} << w_g;
  // A new event on a line already pending merges and is flagged, unless that line is granted now.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p     <= '0;
      r_valid <= 1'b0;
      r_sel   <= '0;
      r_lost  <= 1'b0;
      r_ptr   <= 3'd7;
    end else begin
      r_p    <= (r_p & ~w_gmask) | w_in;
      r_lost <= r_lost | (|(w_in & r_p & ~w_gmask));
      if (w_free) r_valid <= w_grant;
      if (w_grant) begin
        r_sel <= w_g;
        r_ptr <= w_g;
      end
    end
  end
  assign bus.valid = r_valid;
  assign {bus.sel2, bus.sel1, bus.sel0} = r_sel;
  assign bus.lost  = r_lost;
endmodule

// File: doc/tc_event_encoder8.md
TC_EVENT_ENCODER8 -- requirements
Module: tc_event_encoder8

Interface
REQ-001 SHALL have parameter RR_MODE, default 0; 0 = fixed priority with lowest index first, 1 = round-robin priority.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have ports in0..in7, input, 1 bit each: event request lines, sampled every cycle.
REQ-005 SHALL have port dis, input, 1 bit: disable; inhibits new grants only.
REQ-006 SHALL have port ready, input, 1 bit: the consumer accepts the presented index.
REQ-007 SHALL have port valid, output, 1 bit: sel0..sel2 hold a granted index.
REQ-008 SHALL have ports sel0, sel1, sel2, output, 1 bit each: the binary-encoded granted index, with sel0 as the LSB.
REQ-009 SHALL have port lost, output, 1 bit: sticky flag; an event merged into one already pending.
REQ-010 SHALL register all outputs; there SHALL be no combinational path from any input to any output.

Function
REQ-011 SHALL keep an 8-bit pending register P. Each cycle, P SHALL OR in the in0..in7 lines sampled at that edge.
REQ-012 Output slot "free" at an edge SHALL mean: valid == 0, or (valid == 1 and ready == 1). A handshake occurs when valid and ready are both 1.
REQ-013 At an edge where the slot is free and dis == 0, the block SHALL load:
- if P != 0: choose index g from P; set sel <= g and valid <= 1; clear P[g] in the same update (in_g at that same edge SHALL re-set P[g]).
- if P == 0: valid <= 0; sel SHALL hold its value.
REQ-014 At an edge where the slot is free and dis == 1, the block SHALL set valid <= 0 and make no grant. P SHALL still capture inputs.
REQ-015 When the slot is not free, valid and sel SHALL hold stable, whatever the state of dis, P and in.
REQ-016 With RR_MODE = 0, g SHALL be the lowest set index of P.
REQ-017 With RR_MODE = 1, g SHALL be the first set index of P, searching upward from (last granted + 1) mod 8 and wrapping 7 -> 0.
REQ-018 With RR_MODE = 1, the last-granted pointer SHALL update only when a grant is made.
REQ-019 Latency: an event at edge N sets P at edge N. With the slot free and no higher-priority pending, valid = 1 with that index follows at edge N+1.
REQ-020 Only the selection at REQ-013 SHALL remove a pending event; a handshake SHALL NOT alter P.
REQ-021 lost SHALL set at any edge where in_i = 1, P[i] = 1, and i is not being granted at that edge. lost SHALL stay 1 until rst.
REQ-022 Several simultaneous events SHALL each be granted exactly once, one per free slot, in the order given by the priority mode.
REQ-023 Throughput SHALL be one grant per cycle while ready stays high and P != 0.

Reset
REQ-024 While rst == 1 at an edge, the block SHALL set: P = 0, valid = 0, sel0..sel2 = 0, lost = 0, round-robin pointer = 7 (so the first search starts at index 0).
REQ-025 rst SHALL override all other inputs. Events and the ready input at a reset edge SHALL be discarded.
REQ-026 Reset mid-operation SHALL drop a presented-but-unaccepted grant and all pending events, with no later grant for them.

Verification
REQ-027 in3 pulsed for one cycle at edge 1, ready = 1 throughout -> valid = 1 with sel = 3 after edge 2 for exactly one cycle, then valid = 0.
REQ-028 RR_MODE = 0; in0, in5, in7 pulsed together, ready = 1 -> sel = 0, 5, 7 on three consecutive cycles, then valid = 0; lost = 0.
REQ-029 RR_MODE = 1; in2 and in6 held high continuously -> grants alternate 2, 6, 2, 6. RR_MODE = 0 with the same stimulus -> 2, 2, 2.
REQ-030 Backpressure: valid = 1 with sel = 1 and ready = 0 for 5 cycles while in4 pulses -> sel = 1 stays stable; after ready = 1, grants are 1 then 4.
REQ-031 in2 pulsed twice while P[2] is still pending (ready = 0) -> lost = 1 and stays 1; index 2 is granted only once.
REQ-032 dis = 1 with P = 0x81 -> valid stays 0. dis = 0 -> grants are 0 then 7. Then rst during valid = 1 -> all outputs 0 on the next cycle and no further grants.
